// File: rtl/sd_101_pattern_tx_if.sv
// rtl/sd_101_pattern_tx_if.sv - job request and serial output bundle for the 101 pattern transmitter
interface sd_101_pattern_tx_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    localparam int LEN_W = $clog2(WIDTH + 1);

    logic                 start;
    logic [WIDTH-1:0]     pattern;
    logic [LEN_W-1:0]     len;
    logic [3:0]           reps;
    logic [3:0]           gap;
    logic                 dout;
    logic                 dout_valid;
    logic                 busy;
    logic                 done;
    logic [CNT_W-1:0]     exp_count;
    logic [2:0]           led;

    // Job issuer: drives the request, observes the serial stream.
    modport master (
        output start, pattern, len, reps, gap,
        input  dout, dout_valid, busy, done, exp_count, led
    );

    // Transmitter: consumes the request, drives the serial stream.
    modport slave (
        input  start, pattern, len, reps, gap,
        output dout, dout_valid, busy, done, exp_count, led
    );
endinterface

// File: rtl/sd_101_pattern_tx.sv
// rtl/sd_101_pattern_tx.sv - MSB-first frame shifter with golden overlapping "101" counter
module sd_101_pattern_tx #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    sd_101_pattern_tx_if.slave  bus
);
    localparam int LEN_W = $clog2(WIDTH + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   pat_r;        // frame left-aligned so the first bit sits at the MSB
    logic [WIDTH-1:0]   sh;           // working copy of the current frame
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   bits_left;    // bits still to drive after the one on dout
    logic [3:0]         frames_left;  // frames still to send after the current one
    logic [3:0]         gap_r;
    logic [3:0]         gap_cnt;
    logic [1:0]         hist;         // last two driven bits, hist[1] is older

    logic [LEN_W-1:0]   len_clamped;
    logic [WIDTH-1:0]   pattern_aligned;

    // Clamp the requested length and left-align the used bits of the pattern.
    always_comb begin
        len_clamped     = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
        pattern_aligned = bus.pattern << (LEN_MAX - len_clamped);
    end

    // Next golden count when bit b follows history h; completes "101" when h is "10".
    function automatic logic [CNT_W-1:0] count_step(input logic [CNT_W-1:0] c,
                                                    input logic [1:0] h,
                                                    input logic b);
        if (h == 2'b10 && b && c != CNT_MAX)
            return c + 1'b1;
        return c;
    endfunction

    // Job sequencer: frame shifting, inter-frame gaps, done pulse and golden count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            pat_r          <= '0;
            sh             <= '0;
            len_r          <= '0;
            bits_left      <= '0;
            frames_left    <= '0;
            gap_r          <= '0;
            gap_cnt        <= '0;
            hist           <= '0;
            bus.dout       <= 1'b0;
            bus.dout_valid <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.exp_count  <= '0;
            bus.led        <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start && bus.len != '0) begin
                        state          <= SHIFT;
                        pat_r          <= pattern_aligned;
                        sh             <= pattern_aligned;
                        len_r          <= len_clamped;
                        bits_left      <= len_clamped - 1'b1;
                        frames_left    <= (bus.reps == 4'd0) ? 4'd0 : bus.reps - 4'd1;
                        gap_r          <= bus.gap;
                        hist           <= {1'b0, pattern_aligned[WIDTH-1]};
                        bus.exp_count  <= '0;
                        bus.busy       <= 1'b1;
                        bus.dout_valid <= 1'b1;
                        bus.dout       <= pattern_aligned[WIDTH-1];
                        bus.led        <= 3'b001;
                    end
                end
                SHIFT: begin
                    if (bits_left != '0) begin
                        sh            <= sh << 1;
                        bits_left     <= bits_left - 1'b1;
                        bus.dout      <= sh[WIDTH-2];
                        hist          <= {hist[0], sh[WIDTH-2]};
                        bus.exp_count <= count_step(bus.exp_count, hist, sh[WIDTH-2]);
                    end else if (frames_left != 4'd0) begin
                        if (gap_r != 4'd0) begin
                            // The detector sees gap zeros too, so they feed the count.
                            state          <= GAP;
                            gap_cnt        <= gap_r;
                            bus.dout       <= 1'b0;
                            bus.dout_valid <= 1'b0;
                            bus.led        <= 3'b010;
                            hist           <= {hist[0], 1'b0};
                            bus.exp_count  <= count_step(bus.exp_count, hist, 1'b0);
                        end else begin
                            sh            <= pat_r;
                            bits_left     <= len_r - 1'b1;
                            frames_left   <= frames_left - 4'd1;
                            bus.dout      <= pat_r[WIDTH-1];
                            hist          <= {hist[0], pat_r[WIDTH-1]};
                            bus.exp_count <= count_step(bus.exp_count, hist, pat_r[WIDTH-1]);
                        end
                    end else begin
                        state          <= DONE;
                        bus.done       <= 1'b1;
                        bus.busy       <= 1'b0;
                        bus.dout       <= 1'b0;
                        bus.dout_valid <= 1'b0;
                        bus.led        <= 3'b100;
                    end
                end
                GAP: begin
                    if (gap_cnt == 4'd1) begin
                        state          <= SHIFT;
                        sh             <= pat_r;
                        bits_left      <= len_r - 1'b1;
                        frames_left    <= frames_left - 4'd1;
                        bus.dout       <= pat_r[WIDTH-1];
                        bus.dout_valid <= 1'b1;
                        bus.led        <= 3'b001;
                        hist           <= {hist[0], pat_r[WIDTH-1]};
                        bus.exp_count  <= count_step(bus.exp_count, hist, pat_r[WIDTH-1]);
                    end else begin
                        gap_cnt       <= gap_cnt - 4'd1;
                        bus.dout      <= 1'b0;
                        hist          <= {hist[0], 1'b0};
                        bus.exp_count <= count_step(bus.exp_count, hist, 1'b0);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                    bus.led  <= 3'b000;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_101_pattern_tx.sv
// tb/tb_sd_101_pattern_tx.sv - randomized self-checking bench for sd_101_pattern_tx
module tb_sd_101_pattern_tx;
    localparam int WIDTH = 16;
    localparam int CNT_W = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    sd_101_pattern_tx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    sd_101_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       dout;
        logic       valid;
        logic       busy;
        logic       done;
        logic [2:0] led;
        int         cnt;
    } exp_t;

    exp_t        q[$];
    int          hold_cnt;
    bit          model_idle;
    int          n_cmp;
    int          n_bad;
    int          done_seen;
    bit          done_flag;
    logic [31:0] obs_bits;
    int          job_cycles;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected per-cycle outputs of a whole job, built from the stream it must produce.
    task automatic plan_job(input logic [15:0] p, input int l, input int r, input int g);
        int   nl;
        int   nr;
        int   cnt;
        int   bits[$];
        int   vld[$];
        exp_t e;
        nl = (l > WIDTH) ? WIDTH : l;
        nr = (r == 0) ? 1 : r;
        for (int f = 0; f < nr; f++) begin
            for (int i = nl - 1; i >= 0; i--) begin
                bits.push_back(((p >> i) & 16'd1) != 0 ? 1 : 0);
                vld.push_back(1);
            end
            if (f < nr - 1)
                for (int k = 0; k < g; k++) begin
                    bits.push_back(0);
                    vld.push_back(0);
                end
        end
        cnt = 0;
        for (int k = 0; k < bits.size(); k++) begin
            if (k >= 2 && bits[k-2] == 1 && bits[k-1] == 0 && bits[k] == 1 && cnt < CMAX)
                cnt++;
            e.dout  = bits[k][0];
            e.valid = vld[k][0];
            e.busy  = 1'b1;
            e.done  = 1'b0;
            e.led   = vld[k] ? 3'b001 : 3'b010;
            e.cnt   = cnt;
            q.push_back(e);
        end
        e.dout  = 1'b0;
        e.valid = 1'b0;
        e.busy  = 1'b0;
        e.done  = 1'b1;
        e.led   = 3'b100;
        e.cnt   = cnt;
        q.push_back(e);
        hold_cnt = cnt;
    endtask

    // Compare DUT outputs against the model for the current cycle.
    task automatic check();
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            model_idle = 1'b0;
        end else begin
            e.dout  = 1'b0;
            e.valid = 1'b0;
            e.busy  = 1'b0;
            e.done  = 1'b0;
            e.led   = 3'b000;
            e.cnt   = hold_cnt;
            model_idle = 1'b1;
        end
        cmp("dout",       32'(bus.dout),       32'(e.dout));
        cmp("dout_valid", 32'(bus.dout_valid), 32'(e.valid));
        cmp("busy",       32'(bus.busy),       32'(e.busy));
        cmp("done",       32'(bus.done),       32'(e.done));
        cmp("led",        32'(bus.led),        32'(e.led));
        cmp("exp_count",  32'(bus.exp_count),  32'(e.cnt));
        done_flag = bus.done;
        if (bus.done) done_seen++;
        if (bus.dout_valid) obs_bits = {obs_bits[30:0], bus.dout};
    endtask

    // One clock: let the model accept a start if the DUT is idle, then check after the edge.
    task automatic tick();
        if (model_idle && !reset && bus.start && bus.len != '0)
            plan_job(bus.pattern, int'(bus.len), int'(bus.reps), int'(bus.gap));
        @(posedge clk);
        @(negedge clk);
        check();
    endtask

    task automatic run_job(input logic [15:0] p, input int l, input int r, input int g);
        bus.pattern = p;
        bus.len     = 5'(l);
        bus.reps    = 4'(r);
        bus.gap     = 4'(g);
        bus.start   = 1'b1;
        obs_bits    = '0;
        job_cycles  = 0;
        tick();
        job_cycles++;
        bus.start = 1'b0;
        while (!done_flag && job_cycles < 400) begin
            tick();
            job_cycles++;
        end
        if (!done_flag) begin
            n_cmp++;
            n_bad++;
            $display("FAIL job_timeout: got no done expected done within 400 cycles");
        end
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        n_cmp = 0; n_bad = 0; done_seen = 0; hold_cnt = 0;
        model_idle = 1'b1; done_flag = 1'b0; obs_bits = '0;
        bus.start = 1'b0; bus.pattern = '0; bus.len = '0; bus.reps = '0; bus.gap = '0;

        @(negedge clk);
        cmp("rst_dout",  32'(bus.dout),       0);
        cmp("rst_valid", 32'(bus.dout_valid), 0);
        cmp("rst_busy",  32'(bus.busy),       0);
        cmp("rst_done",  32'(bus.done),       0);
        cmp("rst_led",   32'(bus.led),        0);
        cmp("rst_cnt",   32'(bus.exp_count),  0);
        reset = 1'b0;
        tick();

        // Case 1: 101 once.
        run_job(16'h0005, 3, 1, 0);
        cmp("c1_bits",   obs_bits, 32'b101);
        cmp("c1_cycles", 32'(job_cycles), 4);
        cmp("c1_cnt",    32'(bus.exp_count), 1);

        // Case 2: overlapping 10101.
        run_job(16'h0015, 5, 1, 0);
        cmp("c2_bits",   obs_bits, 32'b10101);
        cmp("c2_cycles", 32'(job_cycles), 6);
        cmp("c2_cnt",    32'(bus.exp_count), 2);

        // Case 3: three back-to-back frames.
        run_job(16'h0005, 3, 3, 0);
        cmp("c3_bits",   obs_bits, 32'b101101101);
        cmp("c3_cycles", 32'(job_cycles), 10);
        cmp("c3_cnt",    32'(bus.exp_count), 3);

        // Case 4: single-bit frames with a one-cycle gap that forms 101.
        run_job(16'h0001, 1, 2, 1);
        cmp("c4_bits",   obs_bits, 32'b11);
        cmp("c4_cycles", 32'(job_cycles), 4);
        cmp("c4_cnt",    32'(bus.exp_count), 1);

        // Case 5: start held through a job, then a len=0 start.
        d0 = done_seen;
        bus.pattern = 16'h0005; bus.len = 5'd3; bus.reps = 4'd1; bus.gap = 4'd0;
        bus.start = 1'b1;
        for (int i = 0; i < 50 && !done_flag; i++) tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        cmp("c5_done_pulses", 32'(done_seen - d0), 1);
        bus.len = 5'd0;
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        cmp("c5_len0_busy", 32'(bus.busy), 0);
        cmp("c5_len0_done", 32'(bus.done), 0);
        bus.start = 1'b0;
        tick();

        // Case 6: reset during bit 2 of a 5-bit frame, then replay case 1.
        bus.pattern = 16'h0015; bus.len = 5'd5; bus.reps = 4'd1; bus.gap = 4'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        d0 = done_seen;
        #2 reset = 1'b1;
        #1;
        cmp("c6_dout",  32'(bus.dout),       0);
        cmp("c6_valid", 32'(bus.dout_valid), 0);
        cmp("c6_busy",  32'(bus.busy),       0);
        cmp("c6_cnt",   32'(bus.exp_count),  0);
        cmp("c6_led",   32'(bus.led),        0);
        q.delete();
        hold_cnt = 0;
        model_idle = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        cmp("c6_no_done", 32'(done_seen - d0), 0);
        run_job(16'h0005, 3, 1, 0);
        cmp("c6_replay_bits",   obs_bits, 32'b101);
        cmp("c6_replay_cycles", 32'(job_cycles), 4);
        cmp("c6_replay_cnt",    32'(bus.exp_count), 1);

        // Saturation of the golden counter.
        run_job(16'h5555, 16, 15, 0);
        cmp("sat_cnt", 32'(bus.exp_count), CMAX);

        // Randomized traffic, including clamped lengths and starts while busy.
        for (int i = 0; i < 600; i++) begin
            bus.start   = ($urandom_range(0, 3) == 0);
            bus.pattern = 16'($urandom);
            bus.len     = 5'($urandom_range(0, 20));
            bus.reps    = 4'($urandom_range(0, 3));
            bus.gap     = 4'($urandom_range(0, 3));
            tick();
        end
        bus.start = 1'b0;
        for (int i = 0; i < 200; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
